// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// S1 registers per-bit generate/propagate/xor terms; S2 resolves two-level lookahead carries.
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int GROUPS = WIDTH / 4;

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             c0_q, c0_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic             out_load;
    logic             in_fire;
    logic [WIDTH-1:0] b_mod;

    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   grp_c;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum;
    logic [3:0]        gk;
    logic [3:0]        pk;
    logic              term;
    logic              acc;

    assign out_load = !out_vld_q || out_ready;
    assign in_ready = !s1_vld_q || out_load;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        b_mod    = in_op ? ~in_b : in_b;
        s1_vld_d = in_ready ? in_valid : s1_vld_q;
        g_d      = g_q;
        p_d      = p_q;
        x_d      = x_q;
        c0_d     = c0_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        if (in_fire) begin
            g_d     = in_a & b_mod;
            p_d     = in_a | b_mod;
            x_d     = in_a ^ b_mod;
            c0_d    = in_op ? 1'b1 : in_ci;
            a_msb_d = in_a[WIDTH-1];
            b_msb_d = b_mod[WIDTH-1];
        end
    end

    // Group carries are flattened sum-of-products over all lower groups, so no
    // carry ripples from one group into the next.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        carry = '0;
        gk    = '0;
        pk    = '0;
        term  = 1'b0;
        acc   = 1'b0;
        for (int k = 0; k < GROUPS; k++) begin
            gk = g_q[4*k +: 4];
            pk = p_q[4*k +: 4];
            grp_g[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                     | (pk[3] & pk[2] & pk[1] & gk[0]);
            grp_p[k] = &pk;
        end
        grp_c[0] = c0_q;
        for (int k = 0; k < GROUPS; k++) begin
            term = c0_q;
            for (int j = 0; j <= k; j++) term = term & grp_p[j];
            acc = term;
            for (int j = 0; j <= k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
                acc = acc | term;
            end
            grp_c[k+1] = acc;
        end
        for (int k = 0; k < GROUPS; k++) begin
            gk = g_q[4*k +: 4];
            pk = p_q[4*k +: 4];
            carry[4*k]   = grp_c[k];
            carry[4*k+1] = gk[0] | (pk[0] & grp_c[k]);
            carry[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & grp_c[k]);
            carry[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                         | (pk[2] & pk[1] & pk[0] & grp_c[k]);
        end
    end

    assign sum = x_q ^ carry;

    // Flags hold their last value when the output register empties.
    always_comb begin
        out_vld_d = out_vld_q;
        s_d       = s_q;
        co_d      = co_q;
        ovf_d     = ovf_q;
        if (out_load) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s_d   = sum;
                co_d  = grp_c[GROUPS];
                ovf_d = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q  <= 1'b0;
            g_q       <= '0;
            p_q       <= '0;
            x_q       <= '0;
            c0_q      <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            out_vld_q <= 1'b0;
            s_q       <= '0;
            co_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            g_q       <= g_d;
            p_q       <= p_d;
            x_q       <= x_d;
            c0_q      <= c0_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            out_vld_q <= out_vld_d;
            s_q       <= s_d;
            co_q      <= co_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_s     = s_q;
    assign out_co    = co_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Carries inside each group are computed by lookahead. A second lookahead level computes the carry into each group.
- Provides a valid/ready stream interface with full backpressure, plus carry-out and signed-overflow flags.
- Used as the datapath adder for wider ALU and accumulator blocks.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of 4, range 4..64.
- GROUPS, WIDTH/4, number of 4-bit lookahead groups. Derived; not to be overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept an input this cycle.
- in_op  in  1  0 = add (a+b+ci), 1 = subtract (a-b; ci ignored).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_ci  in  1  carry in, used only when in_op=0.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_s  out  WIDTH  sum or difference, modulo 2^WIDTH.
- out_co  out  1  carry out. For subtract, 1 means no borrow (a >= b unsigned).
- out_ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - The reset_n low edge asynchronously clears the S1 valid flag, out_valid, out_s, out_co and out_ovf to 0.
  - The in-flight operation is discarded.
  - in_ready is 1 once reset_n is high, since the pipeline is empty.
- Operand preparation (combinational, before the S1 register):
  - b' = in_op ? ~in_b : in_b.
  - c0 = in_op ? 1 : in_ci.
- Stage S1 (registered):
  - Stores per-bit g = a & b', p = a | b', x = a ^ b'.
  - Also stores c0, a[WIDTH-1] and b'[WIDTH-1], plus the S1 valid flag.
- Stage S2 (between the S1 and output registers):
  - Per group k, compute group generate G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0 and group propagate P_k = p3p2p1p0.
  - Second level: C_0 = c0, C_{k+1} = G_k | (P_k & C_k), flattened as lookahead (no ripple across groups).
  - In-group carries are c1..c3 from the 4-bit lookahead equations, using C_k as the group carry in.
  - s[i] = x[i] ^ c[i].
  - out_co = C_GROUPS.
  - out_ovf = (a_msb == b'_msb) & (s_msb != a_msb).
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Advance rules:
  - out_load = !out_valid | out_ready.
  - S1 moves into the output register when S1 valid & out_load.
  - in_ready = !S1valid | out_load (combinational).
  - When no transfer occurs, the S1 and output registers hold their values.
- Output on no new data: if out_load is true and S1 is empty, out_valid drops to 0 and out_s/out_co/out_ovf hold their last values.
- Latency and throughput:
  - With out_ready held at 1, a result is valid exactly 2 cycles after its input transfer.
  - Throughput is 1 operation per cycle.
- Stall and ordering:
  - While out_valid=1 and out_ready=0, out_s/out_co/out_ovf are stable.
  - Capacity is 2 operations (S1 plus output); a third is refused via in_ready=0.
  - Results leave in input order; none are dropped or duplicated.
- Simultaneous events: an output transfer and an input transfer may occur in the same cycle while full; both registers advance.
- Reset mid-operation: all queued results are lost. The first post-reset input behaves as on an empty pipeline.

Test Plan:
- Add carry out (WIDTH=16): add 0xFFFF+0x0001, ci=0 → 2 cycles later out_s=0x0000, co=1, ovf=0.
- Add overflow and carry in:
  - add 0x7FFF+0x0001, ci=0 → out_s=0x8000, co=0, ovf=1.
  - add 0x1234+0x4321, ci=1 → out_s=0x5556, co=0, ovf=0.
- Subtract (ci driven 1, ignored):
  - sub 0x0005-0x0007 → out_s=0xFFFE, co=0, ovf=0.
  - sub 0x8000-0x0001 → out_s=0x7FFF, co=1, ovf=1.
- Backpressure: out_ready=0, offer ops A,B,C back-to-back.
  - A and B are accepted; in_ready=0 on C; outputs stable holding A.
  - Raise out_ready → A, B, C delivered in order on consecutive cycles.
- Streaming: 100 random ops (mixed add/sub) with random in_valid/out_ready.
  - Every result matches a reference model in order.
  - Latency is 2 cycles whenever out_ready stays 1.
- Reset mid-operation: pulse reset_n low asynchronously with 2 ops in flight.
  - out_valid=0 immediately; in_ready=1 after release.
  - A fresh op 0x0001+0x0001 returns 0x0002 two cycles later.
